// File: rtl/seq_calc_core.sv
// Shared iterative arithmetic engine: add/sub/cmp in one pass, mul/div/mod/sqrt/sqr one bit per cycle.
// Operands are captured on start_i; result and flags are registered and presented with a done_o pulse.
module seq_calc_core #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 neg_o,
  output logic                 err_o
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_SQRT = 3'd5;
  localparam logic [2:0] OP_CMP  = 3'd6;
  localparam logic [2:0] OP_SQR  = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b;
  logic [RW-1:0]    acc, acc_s, x, x_s;
  logic [WIDTH-1:0] y, y_s;
  logic [WIDTH+1:0] r, r_s;
  logic [WIDTH:0]   div_trial, div_diff;
  logic [WIDTH+1:0] sq_rem, sq_trial;
  logic             iterative_req;
  logic [RW-1:0]    res;
  logic             neg, err;

  assign iterative_req = !(op_i == OP_ADD || op_i == OP_SUB || op_i == OP_CMP);
  assign busy_o        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // y doubles as multiplier, dividend/quotient shift register, or developing root
  assign div_trial = {r[WIDTH-1:0], y[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, b};
  assign sq_rem    = {r[WIDTH-1:0], x[RW-1 -: 2]};
  assign sq_trial  = {y, 2'b01};

  always_comb begin
    acc_s = acc;
    x_s   = x;
    y_s   = y;
    r_s   = r;
    case (op)
      OP_MUL, OP_SQR: begin
        if (y[0]) acc_s = acc + x;
        x_s = x << 1;
        y_s = y >> 1;
      end
      OP_DIV, OP_MOD: begin
        if (div_trial >= {1'b0, b}) begin
          r_s = {1'b0, div_diff};
          y_s = {y[WIDTH-2:0], 1'b1};
        end else begin
          r_s = {1'b0, div_trial};
          y_s = {y[WIDTH-2:0], 1'b0};
        end
      end
      OP_SQRT: begin
        x_s = x << 2;
        if (sq_rem >= sq_trial) begin
          r_s = sq_rem - sq_trial;
          y_s = {y[WIDTH-2:0], 1'b1};
        end else begin
          r_s = sq_rem;
          y_s = {y[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      op  <= '0;
      a   <= '0;
      b   <= '0;
      acc <= '0;
      x   <= '0;
      y   <= '0;
      r   <= '0;
    end else if (state == IDLE && start_i) begin
      op  <= op_i;
      a   <= a_i;
      b   <= b_i;
      cnt <= iterative_req ? CW'(WIDTH - 1) : '0;
      acc <= '0;
      r   <= '0;
      x   <= (op_i == OP_SQRT) ? {b_i, a_i} : RW'(a_i);
      y   <= (op_i == OP_MUL) ? b_i : (op_i == OP_SQRT) ? '0 : a_i;
    end else if (state == CALC) begin
      cnt <= cnt - CW'(1);
      acc <= acc_s;
      x   <= x_s;
      y   <= y_s;
      r   <= r_s;
    end
  end

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:         res = RW'(a) + RW'(b);
      OP_SUB:         res = RW'(a) - RW'(b);
      OP_CMP:         res = (a == b) ? '0 : (a > b) ? RW'(1) : RW'(2);
      OP_MUL, OP_SQR: res = acc;
      OP_DIV,
      OP_SQRT:        res = RW'(y);
      OP_MOD:         res = RW'(r[WIDTH-1:0]);
      default:        res = '0;
    endcase
  end

  assign neg = (op == OP_SUB) && (a < b);
  assign err = (op == OP_DIV || op == OP_MOD) && (b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_o   <= 1'b0;
      result_o <= '0;
      neg_o    <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      done_o <= (state == DONE);
      if (state == DONE) begin
        result_o <= res;
        neg_o    <= neg;
        err_o    <= err;
      end
    end
  end
endmodule

// File: tb/tb_seq_calc_core.sv
// Directed and random operations against an arithmetic reference model of the calculator core.
module tb_seq_calc_core;
  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [2:0]    op_i = '0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          busy_o, done_o, neg_o, err_o;
  logic [RW-1:0] result_o;

  int tests = 0;
  int fails = 0;

  seq_calc_core #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .neg_o(neg_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions
  task automatic model(input int op, input int a, input int b,
                       output int res, output int neg, output int err);
    int v, q;
    neg = 0;
    err = 0;
    case (op)
      0: res = a + b;
      1: begin res = (a - b) & ((1 << RW) - 1); neg = (a < b) ? 1 : 0; end
      2: begin res = (b == 0) ? (1 << W) - 1 : a / b; err = (b == 0) ? 1 : 0; end
      3: res = a * b;
      4: begin res = (b == 0) ? a : a % b; err = (b == 0) ? 1 : 0; end
      5: begin
        v = b * (1 << W) + a;
        q = 0;
        while ((q + 1) * (q + 1) <= v) q++;
        res = q;
      end
      6: res = (a == b) ? 0 : (a > b) ? 1 : 2;
      default: res = a * a;
    endcase
  endtask

  task automatic run_op(input int op, input int a, input int b, input bit pulse);
    int er, en, ee, lat, cyc, busy_n, extra;
    bit got;
    model(op, a, b, er, en, ee);
    lat = (op == 0 || op == 1 || op == 6) ? 2 : W + 1;
    @(negedge clk);
    start_i = 1'b1;
    op_i = 3'(op);
    a_i = W'(a);
    b_i = W'(b);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    a_i = W'($urandom);
    b_i = W'($urandom);
    op_i = 3'($urandom);
    cyc = 0;
    busy_n = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (busy_o) busy_n++;
      start_i = (pulse && cyc == 1) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      got = done_o;
    end
    start_i = 1'b0;
    check($sformatf("latency op%0d", op), cyc, lat);
    check($sformatf("busy cycles op%0d", op), busy_n, lat);
    check($sformatf("busy at done op%0d", op), 32'(busy_o), 0);
    check($sformatf("result op%0d a=%0d b=%0d", op, a, b), 32'(result_o), er);
    check($sformatf("neg op%0d", op), 32'(neg_o), en);
    check($sformatf("err op%0d", op), 32'(err_o), ee);
    if (pulse) begin
      extra = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        if (done_o) extra++;
      end
      check("ignored start produced no done", extra, 0);
      check("result held", 32'(result_o), er);
    end
  endtask

  initial begin
    int extra, op, a, b;
    #12;
    check("reset busy", 32'(busy_o), 0);
    check("reset done", 32'(done_o), 0);
    check("reset result", 32'(result_o), 0);
    check("reset neg", 32'(neg_o), 0);
    check("reset err", 32'(err_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 9, 7, 1'b0);
    run_op(1, 3, 7, 1'b0);
    run_op(0, 0, 0, 1'b0);
    run_op(3, 15, 15, 1'b1);
    run_op(2, 13, 4, 1'b0);
    run_op(4, 13, 4, 1'b0);
    run_op(2, 9, 0, 1'b0);
    run_op(4, 9, 0, 1'b0);
    run_op(5, 8, 12, 1'b0);
    run_op(5, 15, 15, 1'b0);
    run_op(5, 0, 0, 1'b0);
    run_op(6, 5, 5, 1'b0);
    run_op(6, 2, 9, 1'b1);
    run_op(7, 13, 0, 1'b0);

    // Abort a multiply two cycles in
    @(negedge clk);
    start_i = 1'b1;
    op_i = 3'd3;
    a_i = 4'd15;
    b_i = 4'd15;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy_o), 0);
    check("abort result", 32'(result_o), 0);
    check("abort done", 32'(done_o), 0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done_o) extra++;
      if (i == 2) rst_n = 1'b1;
    end
    check("no done after abort", extra, 0);
    run_op(3, 6, 7, 1'b0);

    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 7));
      a = int'($urandom_range(0, (1 << W) - 1));
      b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
      run_op(op, a, b, ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
